// File: rtl/irq_pkg.sv
// Shared types, limits and the fixed-priority helper for the interrupt aggregator.
package irq_pkg;

  localparam int MAX_SRC  = 32;
  localparam int MAX_SYNC = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } irq_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_condition.sv
// One interrupt channel: synchroniser, polarity, previous-value register and set pulse.
module irq_condition
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic edge_i,
  input  logic invert_i,
  input  logic armed_i,
  output logic set_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cond;

  assign cond = sync_q[SYNC_STAGES-1] ^ invert_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      prev_q <= cond;
    end
  end

  // Level sources bypass arming; only edge detection waits for the chain to fill.
  assign set_o = edge_i ? (cond & ~prev_q & armed_i) : cond;

endmodule

// File: rtl/irq_aggregator.sv
// N_SRC-channel interrupt aggregator: pending/mask latches, fixed-priority pick, REQ/ack handshake.
module irq_aggregator
  import irq_pkg::*;
#(
  parameter  int N_SRC       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_in,
  input  logic [N_SRC-1:0] cfg_edge,
  input  logic [N_SRC-1:0] cfg_invert,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_d,
  input  logic             irq_ack,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask_q
);

  localparam logic [2:0] ARM_CYC = 3'(SYNC_STAGES + 1);

  irq_state_e       state_q, state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] set, clr, elig;
  logic [2:0]       arm_q;
  logic             armed;
  logic             ack_ok;

  assign armed = (arm_q == ARM_CYC);

  for (genvar g = 0; g < N_SRC; g++) begin : g_ch
    irq_condition #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
      .clk      (clk),
      .reset    (reset),
      .src_i    (src_in[g]),
      .edge_i   (cfg_edge[g]),
      .invert_i (cfg_invert[g]),
      .armed_i  (armed),
      .set_o    (set[g])
    );
  end

  assign elig = pending_q & mask_q;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ack_ok   = 1'b0;
    unique case (state_q)
      IDLE: if (|elig) begin
        irq_id_d = ID_W'(lowest_set(MAX_SRC'(elig)));
        state_d  = REQ;
      end
      // ID stays frozen here; a newly arriving higher-priority source waits for the next IDLE.
      REQ: if (irq_ack) begin
        ack_ok  = 1'b1;
        state_d = HOLD;
      end else if (!mask_q[irq_id_q]) begin
        state_d = IDLE;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear so an edge arriving during the ack cycle is not lost.
  always_comb begin
    clr = '0;
    if (ack_ok) clr[irq_id_q] = 1'b1;
    pending_d = (pending_q & ~clr) | set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_id_q  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      arm_q     <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      if (mask_wr) mask_q <= mask_d;
      if (!armed) arm_q <= arm_q + 3'd1;
    end
  end

  assign irq     = (state_q == REQ);
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed scenarios plus a randomized run against a history-based reference model.
module tb_irq_aggregator;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src_in, cfg_edge, cfg_invert, mask_d;
  logic          mask_wr, irq_ack;
  logic          irq;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending, mask_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_aggregator #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .src_in(src_in), .cfg_edge(cfg_edge),
    .cfg_invert(cfg_invert), .mask_wr(mask_wr), .mask_d(mask_d),
    .irq_ack(irq_ack), .irq(irq), .irq_id(irq_id), .pending(pending), .mask_q(mask_q)
  );

  // Reference model: raw samples of the last S edges, so the conditioned line is the sample S edges old.
  logic [N-1:0]  m_raw[$];
  logic [N-1:0]  m_prev, m_pend, m_mask;
  logic [IW-1:0] m_id;
  int            m_live, m_st;   // m_st: 0 idle, 1 requesting, 2 hold

  task automatic tick();
    logic [N-1:0] cond, setv, elig, npend;
    int w;
    @(posedge clk);
    if (reset) begin
      m_raw = {};
      repeat (S) m_raw.push_back('0);
      m_prev = '0; m_pend = '0; m_mask = '0; m_id = '0; m_live = 0; m_st = 0;
    end else begin
      cond = m_raw[0] ^ cfg_invert;
      for (int i = 0; i < N; i++)
        setv[i] = cfg_edge[i] ? (cond[i] & ~m_prev[i] & (m_live >= S + 1)) : cond[i];
      elig = m_pend & m_mask;
      w = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) w = i;
      npend = m_pend;
      if (m_st == 1 && irq_ack) npend[m_id] = 1'b0;
      npend = npend | setv;
      case (m_st)
        0: if (w >= 0) begin m_id = IW'(w); m_st = 1; end
        1: if (irq_ack) m_st = 2; else if (!m_mask[m_id]) m_st = 0;
        default: m_st = 0;
      endcase
      m_pend = npend;
      if (mask_wr) m_mask = mask_d;
      m_prev = cond;
      if (m_live < S + 1) m_live++;
      void'(m_raw.pop_front());
      m_raw.push_back(src_in);
    end
    #1;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_wr = 1'b1; mask_d = m;
    tick();
    mask_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; src_in = '0; cfg_edge = '1; cfg_invert = '0;
    mask_wr = 1'b0; mask_d = '0; irq_ack = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({irq, irq_id, pending, mask_q} !== '0) begin
      n_fail++; $display("FAIL reset_state: got irq=%0b id=%0d pend=%h mask=%h want all 0", irq, irq_id, pending, mask_q);
    end
    reset = 1'b0;
    repeat (S + 2) tick();
    n_tests++;
    if (irq !== 1'b0 || pending !== '0) begin
      n_fail++; $display("FAIL reset_release_idle: got irq=%0b pend=%h want 0/00", irq, pending);
    end
  endtask

  task automatic test_single_edge();
    write_mask(8'hFF);
    n_tests++;
    if (mask_q !== 8'hFF) begin n_fail++; $display("FAIL mask_write: got %h want ff", mask_q); end
    src_in[3] = 1'b1;
    tick(); tick();
    n_tests++;
    if (pending[3] !== 1'b0) begin n_fail++; $display("FAIL edge_early: pending[3]=%0b want 0", pending[3]); end
    tick();
    src_in[3] = 1'b0;
    n_tests++;
    if (pending[3] !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL edge_pending_lat: pend[3]=%0b irq=%0b want 1/0", pending[3], irq);
    end
    tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd3) begin
      n_fail++; $display("FAIL edge_irq_lat: irq=%0b id=%0d want 1/3", irq, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_tests++;
    if (irq !== 1'b0 || pending[3] !== 1'b0) begin
      n_fail++; $display("FAIL edge_ack: irq=%0b pend[3]=%0b want 0/0", irq, pending[3]);
    end
    repeat (4) tick();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_no_repeat: irq=%0b want 0", irq); end
  endtask

  task automatic test_priority_freeze();
    src_in[5] = 1'b1; tick(); tick(); src_in[5] = 1'b0; tick(); tick();
    src_in[1] = 1'b1; tick(); tick(); src_in[1] = 1'b0; tick(); tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd5 || pending[1] !== 1'b1) begin
      n_fail++; $display("FAIL prio_freeze: irq=%0b id=%0d pend=%h want 1/5/pend[1]", irq, irq_id, pending);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tick();
    n_tests++;
    if (irq !== 1'b0 || pending !== 8'h02) begin
      n_fail++; $display("FAIL prio_hold: irq=%0b pend=%h want 0/02", irq, pending);
    end
    tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd1) begin
      n_fail++; $display("FAIL prio_second: irq=%0b id=%0d want 1/1", irq, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_level_rerequest();
    cfg_edge[2] = 1'b0; src_in[2] = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd2) begin
      n_fail++; $display("FAIL level_irq: irq=%0b id=%0d want 1/2", irq, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_tests++;
    if (irq !== 1'b0 || pending[2] !== 1'b1) begin
      n_fail++; $display("FAIL level_hold: irq=%0b pend[2]=%0b want 0/1", irq, pending[2]);
    end
    tick(); tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd2) begin
      n_fail++; $display("FAIL level_rereq: irq=%0b id=%0d want 1/2", irq, irq_id);
    end
    src_in[2] = 1'b0;
    repeat (3) tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (irq !== 1'b0 || pending[2] !== 1'b0) begin
      n_fail++; $display("FAIL level_release: irq=%0b pend[2]=%0b want 0/0", irq, pending[2]);
    end
    cfg_edge[2] = 1'b1;
  endtask

  task automatic test_mask_withdraw();
    write_mask(8'h00);
    src_in[4] = 1'b1; tick(); tick(); src_in[4] = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (pending[4] !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL mask_pending: pend[4]=%0b irq=%0b want 1/0", pending[4], irq);
    end
    write_mask(8'h10);
    tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd4) begin
      n_fail++; $display("FAIL mask_enable: irq=%0b id=%0d want 1/4", irq, irq_id);
    end
    write_mask(8'h00);
    tick();
    n_tests++;
    if (irq !== 1'b0 || pending[4] !== 1'b1) begin
      n_fail++; $display("FAIL mask_withdraw: irq=%0b pend[4]=%0b want 0/1", irq, pending[4]);
    end
  endtask

  task automatic test_reset_boundaries();
    reset = 1'b1; src_in = 8'h01; cfg_edge = '1; cfg_invert = 8'h40;
    tick(); tick();
    reset = 1'b0;
    write_mask(8'hFF);
    repeat (8) tick();
    n_tests++;
    if (irq !== 1'b0 || pending !== 8'h00) begin
      n_fail++; $display("FAIL reset_active_line: irq=%0b pend=%h want 0/00", irq, pending);
    end
    src_in[5] = 1'b1; tick(); tick(); src_in[5] = 1'b0; tick(); tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_pre_req: irq=%0b want 1", irq); end
    reset = 1'b1; tick();
    n_tests++;
    if ({irq, irq_id, pending, mask_q} !== '0) begin
      n_fail++; $display("FAIL reset_mid_req: irq=%0b id=%0d pend=%h mask=%h want all 0", irq, irq_id, pending, mask_q);
    end
    src_in = '0; cfg_invert = '0;
    reset = 1'b0;
    repeat (S + 2) tick();
  endtask

  task automatic test_collision();
    write_mask(8'hFF);
    src_in[3] = 1'b1; tick(); tick(); src_in[3] = 1'b0; tick(); tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd3) begin
      n_fail++; $display("FAIL coll_first: irq=%0b id=%0d want 1/3", irq, irq_id);
    end
    src_in[3] = 1'b1; tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; src_in[3] = 1'b0;
    n_tests++;
    if (irq !== 1'b0 || pending[3] !== 1'b1) begin
      n_fail++; $display("FAIL coll_set_wins: irq=%0b pend[3]=%0b want 0/1", irq, pending[3]);
    end
    tick(); tick();
    n_tests++;
    if (irq !== 1'b1 || irq_id !== 3'd3) begin
      n_fail++; $display("FAIL coll_second: irq=%0b id=%0d want 1/3", irq, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (irq !== 1'b0 || pending !== 8'h00) begin
      n_fail++; $display("FAIL coll_done: irq=%0b pend=%h want 0/00", irq, pending);
    end
  endtask

  task automatic test_random();
    reset = 1'b1; src_in = '0; irq_ack = 1'b0; mask_wr = 1'b0;
    cfg_edge = 8'($urandom); cfg_invert = 8'($urandom);
    tick(); reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) src_in[i] = ~src_in[i];
      mask_wr = ($urandom_range(0, 11) == 0);
      mask_d  = 8'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      if (c == 400) cfg_edge = 8'($urandom);
      tick();
      n_tests++;
      if ({irq, irq_id, pending, mask_q} !== {(m_st == 1), m_id, m_pend, m_mask}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got irq=%0b id=%0d pend=%h mask=%h want irq=%0b id=%0d pend=%h mask=%h",
                 c, irq, irq_id, pending, mask_q, (m_st == 1), m_id, m_pend, m_mask);
      end
    end
    irq_ack = 1'b0; mask_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority_freeze();
    test_level_rerequest();
    test_mask_withdraw();
    test_reset_boundaries();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
